pingpang_nbank: RTL

Parametrised successor to the two-bank ping-pong buffer: NBANK banks of DEPTH words, DATA_W bits each, with bank switching driven internally rather than by an external `switch` signal. The write side fills banks round-robin; the read side drains completed banks in the same order. Both sides use valid/ready handshakes. A `flush` input closes a partially filled bank. The block sits between a streaming producer (data_gen-style) and a block-oriented consumer.

---
 rtl/pingpang_pkg.sv | 11 +
 rtl/pingpang_bank.sv | 56 +++++
 rtl/pingpang_nbank.sv | 110 +++++++++++
 3 files changed

// File: rtl/pingpang_pkg.sv
// Shared types for the N-bank ping-pong buffer.
package pingpang_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/pingpang_bank.sv
// One buffer bank: DEPTH x DATA_W storage plus its lifecycle state and closed word count.
module pingpang_bank
  import pingpang_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_close,
  input  logic [CW-1:0]     i_close_cnt,
  input  logic              i_rd_en,
  input  logic              i_rd_last,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output bank_state_t       o_state,
  output logic [CW-1:0]     o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  bank_state_t       r_state;
  logic [CW-1:0]     r_count;

  // Storage needs no reset: the bank state alone decides whether contents are visible.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_count <= '0;
    end else if (i_close) begin
      r_state <= FULL;
      r_count <= i_close_cnt;
    end else if (i_wr_en) begin
      r_state <= FILLING;
    end else if (i_rd_last) begin
      r_state <= EMPTY;
    end else if (i_rd_en) begin
      r_state <= DRAINING;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
  assign o_state   = r_state;
  assign o_count   = r_count;

endmodule

// File: rtl/pingpang_nbank.sv
// N-bank ping-pong buffer: round-robin fill on the write side, in-order drain on the read side.
module pingpang_nbank
  import pingpang_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NBANK  = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [DATA_W-1:0]          i_in_data,
  input  logic                       i_flush,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [DATA_W-1:0]          o_out_data,
  output logic                       o_out_last,
  output logic [$clog2(NBANK)-1:0]   o_out_bank,
  output logic [$clog2(NBANK+1)-1:0] o_full_banks
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(NBANK);
  localparam int unsigned FW = $clog2(NBANK + 1);

  logic [BW-1:0] r_wr_bank, r_rd_bank;
  logic [AW-1:0] r_wr_addr, r_rd_addr;
  logic [FW-1:0] r_full_banks;

  bank_state_t       w_state   [NBANK];
  logic [CW-1:0]     w_count   [NBANK];
  logic [DATA_W-1:0] w_rd_data [NBANK];

  logic          w_wr_fire, w_close, w_rd_fire, w_last_fire;
  logic [CW-1:0] w_close_cnt;

  assign o_in_ready  = (w_state[r_wr_bank] == EMPTY) || (w_state[r_wr_bank] == FILLING);
  assign w_wr_fire   = i_in_valid && o_in_ready;
  // Flush on an untouched bank with no write is a no-op; a full-bank write closes exactly once.
  assign w_close     = (w_wr_fire && (r_wr_addr == AW'(DEPTH - 1))) ||
                       (i_flush && ((r_wr_addr != '0) || w_wr_fire));
  assign w_close_cnt = CW'(r_wr_addr) + CW'(w_wr_fire);

  assign o_out_valid = (w_state[r_rd_bank] == FULL) || (w_state[r_rd_bank] == DRAINING);
  assign o_out_data  = o_out_valid ? w_rd_data[r_rd_bank] : '0;
  assign o_out_last  = o_out_valid && (CW'(r_rd_addr) == w_count[r_rd_bank] - CW'(1));
  assign w_rd_fire   = o_out_valid && i_out_ready;
  assign w_last_fire = w_rd_fire && o_out_last;

  assign o_out_bank   = r_rd_bank;
  assign o_full_banks = r_full_banks;

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    localparam logic [BW-1:0] Idx = BW'(g);

    pingpang_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .CW     (CW)
    ) u_bank (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr_en     (w_wr_fire && (r_wr_bank == Idx)),
      .i_wr_addr   (r_wr_addr),
      .i_wr_data   (i_in_data),
      .i_close     (w_close && (r_wr_bank == Idx)),
      .i_close_cnt (w_close_cnt),
      .i_rd_en     (w_rd_fire && (r_rd_bank == Idx)),
      .i_rd_last   (w_last_fire && (r_rd_bank == Idx)),
      .i_rd_addr   (r_rd_addr),
      .o_rd_data   (w_rd_data[g]),
      .o_state     (w_state[g]),
      .o_count     (w_count[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_bank    <= '0;
      r_wr_addr    <= '0;
      r_rd_bank    <= '0;
      r_rd_addr    <= '0;
      r_full_banks <= '0;
    end else begin
      if (w_close) begin
        r_wr_addr <= '0;
        r_wr_bank <= (r_wr_bank == BW'(NBANK - 1)) ? '0 : r_wr_bank + BW'(1);
      end else if (w_wr_fire) begin
        r_wr_addr <= r_wr_addr + AW'(1);
      end

      if (w_last_fire) begin
        r_rd_addr <= '0;
        r_rd_bank <= (r_rd_bank == BW'(NBANK - 1)) ? '0 : r_rd_bank + BW'(1);
      end else if (w_rd_fire) begin
        r_rd_addr <= r_rd_addr + AW'(1);
      end

      case ({w_close, w_last_fire})
        2'b10:   r_full_banks <= r_full_banks + FW'(1);
        2'b01:   r_full_banks <= r_full_banks - FW'(1);
        default: r_full_banks <= r_full_banks;
      endcase
    end
  end

endmodule
